// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int DATA_W_DEFAULT = 8;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first asserted request searching
// circularly from the slot after the last winner.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign cand[k] = IDX_W'((int'(last) + k + 1) % NUM_REQ);
  end

  // Walk from lowest to highest priority so the closest candidate overwrites.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid  = 1'b1;
        winner = cand[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one single-frame UART transmitter among
// several byte requesters, with a start timeout and sticky error flag.
module uart_tx_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int START_TIMEOUT = 16,
  localparam int OWN_W        = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      active,
  output logic [OWN_W-1:0]          owner,
  output logic                      err_timeout
);

  localparam int CNT_W = idx_width(START_TIMEOUT);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                tx_send_q, tx_send_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                active_q, active_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pick_valid;
  logic [OWN_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWN_W)
  ) u_pick (
    .req    (req),
    .last   (owner_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    active_d  = active_q;
    owner_d   = owner_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      // A frame still in flight from before reset blocks any new launch.
      IDLE: begin
        if (!tx_busy && pick_valid) begin
          owner_d   = pick_idx;
          tx_data_d = req_bytes[pick_idx];
          tx_send_d = 1'b1;
          grant_d   = NUM_REQ'(1) << pick_idx;
          active_d  = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner resets to the last slot so requester 0 wins the first round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      active_q  <= 1'b0;
      owner_q   <= OWN_W'(NUM_REQ - 1);
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      active_q  <= active_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign active      = active_q;
  assign owner       = owner_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Self-checking bench for uart_tx_rr_arbiter: directed scenarios plus a
// randomized phase, all checked against a round-robin reference model.
module tb_uart_tx_rr_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_W        = 8;
  localparam int START_TIMEOUT = 16;
  localparam int OWN_W         = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_send;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      active;
  logic [OWN_W-1:0]          owner;
  logic                      err_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  bit auto_drop = 1'b1;

  always #5 clk = ~clk;

  uart_tx_rr_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_W        (DATA_W),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .active      (active),
    .owner       (owner),
    .err_timeout (err_timeout)
  );

  // UART TX model: busy rises the cycle after a send and lasts busy_len cycles.
  logic model_busy = 1'b0;
  int   busy_left = 0;
  int   busy_len = 10;
  bit   tx_never = 1'b0;
  bit   ext_busy = 1'b0;

  assign tx_busy = model_busy | ext_busy;

  always @(posedge clk) begin
    if (tx_send && !tx_never) begin
      model_busy <= 1'b1;
      busy_left  <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin choice: first requester after `last`, circularly.
  function automatic int refPick(input logic [NUM_REQ-1:0] r, input int last);
    int res;
    res = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (res < 0 && r[(last + k) % NUM_REQ]) res = (last + k) % NUM_REQ;
    end
    return res;
  endfunction

  // Request/data as seen by the DUT at the most recent rising edge.
  logic [NUM_REQ-1:0]        req_prev = '0;
  logic [NUM_REQ*DATA_W-1:0] data_prev = '0;

  always @(posedge clk) begin
    req_prev  = req;
    data_prev = req_data;
  end

  int                 ref_owner = NUM_REQ - 1;
  logic [DATA_W-1:0]  last_data = '0;
  bit                 prev_active = 1'b0;
  int                 grant_log[$];
  int                 wait_frames[NUM_REQ];
  int                 mon_w;
  logic [NUM_REQ-1:0] mon_exp;

  // Scoreboard: every grant must be the reference winner with its byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      ref_owner   = NUM_REQ - 1;
      last_data   = '0;
      prev_active = 1'b0;
      grant_log.delete();
      for (int i = 0; i < NUM_REQ; i++) wait_frames[i] = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) if (!req_prev[i]) wait_frames[i] = 0;
      checkOutput("send_with_grant", 32'(tx_send), 32'(grant != '0));
      if (grant != '0 || tx_send) begin
        mon_w   = refPick(req_prev, ref_owner);
        mon_exp = (mon_w < 0) ? '0 : (NUM_REQ'(1) << mon_w);
        checkOutput("grant_winner", 32'(grant), 32'(mon_exp));
        checkOutput("gap_before_frame", 32'(prev_active), 32'(0));
        checkOutput("active_at_grant", 32'(active), 32'(1));
        if (mon_w >= 0) begin
          checkOutput("tx_data_winner", 32'(tx_data), 32'(data_prev[mon_w*DATA_W +: DATA_W]));
          checkOutput("owner_winner", 32'(owner), 32'(mon_w));
          checkOutput("no_starvation", 32'(wait_frames[mon_w] < NUM_REQ), 32'(1));
          for (int i = 0; i < NUM_REQ; i++) if (i != mon_w && req_prev[i]) wait_frames[i]++;
          wait_frames[mon_w] = 0;
          ref_owner = mon_w;
          grant_log.push_back(mon_w);
        end
        last_data = tx_data;
      end else begin
        checkOutput("tx_data_held", 32'(tx_data), 32'(last_data));
      end
      prev_active = active;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (auto_drop) req = req & ~grant;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*DATA_W-1:0] d);
    req_data = d;
    req      = r;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'(0));
    checkOutput("rst_send", 32'(tx_send), 32'(0));
    checkOutput("rst_data", 32'(tx_data), 32'(0));
    checkOutput("rst_active", 32'(active), 32'(0));
    checkOutput("rst_owner", 32'(owner), 32'(NUM_REQ - 1));
    checkOutput("rst_err", 32'(err_timeout), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    auto_drop = 1'b1;
    tick();
    grant_log.delete();
  endtask

  task automatic waitGrants(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (grant_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    checkOutput(tag, 32'(grant_log.size()), 32'(n));
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int t;
    t = 0;
    while ((active || tx_busy) && t < budget) begin
      tick();
      t++;
    end
    checkOutput(tag, 32'(active || tx_busy), 32'(0));
  endtask

  task automatic waitSend(input int budget, input string tag, output int lat);
    lat = 0;
    while (!tx_send && lat < budget) begin
      tick();
      lat++;
    end
    checkOutput(tag, 32'(tx_send), 32'(1));
  endtask

  task automatic waitBusy(input logic level, input int budget, input string tag);
    int t;
    t = 0;
    while (tx_busy != level && t < budget) begin
      tick();
      t++;
    end
    checkOutput(tag, 32'(tx_busy), 32'(level));
  endtask

  initial begin
    int lat;
    int sends;
    int cnt2;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    #3;
    doReset();

    // Single request: one-cycle grant and send, frame tracked by active.
    busy_len = 10;
    applyStimulus(4'b0001, 32'h0000_0041);
    waitSend(20, "t1_send_seen", lat);
    checkOutput("t1_latency", 32'(lat), 32'(1));
    checkOutput("t1_grant", 32'(grant), 32'(4'b0001));
    checkOutput("t1_data", 32'(tx_data), 32'(8'h41));
    tick();
    checkOutput("t1_send_pulse", 32'(tx_send), 32'(0));
    checkOutput("t1_grant_pulse", 32'(grant), 32'(0));
    waitBusy(1'b1, 10, "t1_busy_rise");
    waitBusy(1'b0, 20, "t1_busy_fall");
    checkOutput("t1_active_busy", 32'(active), 32'(1));
    tick();
    checkOutput("t1_active_end", 32'(active), 32'(0));
    repeat (10) tick();
    checkOutput("t1_one_frame", 32'(grant_log.size()), 32'(1));
    checkOutput("t1_data_kept", 32'(tx_data), 32'(8'h41));

    // Contention: all four held, grants rotate 0,1,2,3,0.
    doReset();
    busy_len  = 4;
    auto_drop = 1'b0;
    applyStimulus(4'b1111, 32'h3332_3130);
    waitGrants(5, 200, "t2_grants");
    req = '0;
    auto_drop = 1'b1;
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) checkOutput("t2_order", 32'(grant_log[i]), 32'(exp_order[i]));
    end
    waitIdle(50, "t2_idle");

    // Rotation skip: owner 1, then 3 and 0 requesting.
    doReset();
    applyStimulus(4'b0010, 32'h0000_5100);
    waitGrants(1, 30, "t3_first");
    waitIdle(50, "t3_idle");
    applyStimulus(4'b1001, 32'h7300_0070);
    waitGrants(3, 100, "t3_grants");
    if (grant_log.size() >= 3) begin
      checkOutput("t3_first_owner", 32'(grant_log[0]), 32'(1));
      checkOutput("t3_skip_to_3", 32'(grant_log[1]), 32'(3));
      checkOutput("t3_wrap_to_0", 32'(grant_log[2]), 32'(0));
    end
    waitIdle(50, "t3_idle2");

    // Withdraw: requester 2 pulses during another frame and never wins.
    doReset();
    busy_len = 10;
    applyStimulus(4'b0001, 32'h0000_0061);
    waitBusy(1'b1, 20, "t4_busy");
    repeat (2) tick();
    req_data[23:16] = 8'h62;
    req[2] = 1'b1;
    repeat (2) tick();
    req[2] = 1'b0;
    waitIdle(50, "t4_idle");
    repeat (5) tick();
    cnt2 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 2) cnt2++;
    checkOutput("t4_no_grant2", 32'(cnt2), 32'(0));
    checkOutput("t4_one_frame", 32'(grant_log.size()), 32'(1));

    // Timeout: busy never rises; error sets 16 cycles after leaving LAUNCH.
    doReset();
    tx_never = 1'b1;
    applyStimulus(4'b0001, 32'h0000_0071);
    waitSend(20, "t5_send", lat);
    req_data[15:8] = 8'h72;
    req[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) begin
        checkOutput("t5_err_early", 32'(err_timeout), 32'(0));
        checkOutput("t5_active_wait", 32'(active), 32'(1));
      end
      if (k == 17) begin
        checkOutput("t5_err_set", 32'(err_timeout), 32'(1));
        checkOutput("t5_active_drop", 32'(active), 32'(0));
      end
    end
    tx_never = 1'b0;
    waitGrants(2, 30, "t5_next_grant");
    if (grant_log.size() >= 2) checkOutput("t5_next_owner", 32'(grant_log[1]), 32'(1));
    waitIdle(50, "t5_idle");
    checkOutput("t5_err_sticky", 32'(err_timeout), 32'(1));

    // Reset mid-frame with the transmitter still busy.
    busy_len = 30;
    applyStimulus(4'b0001, 32'h0000_0081);
    waitSend(20, "t6_send", lat);
    waitBusy(1'b1, 20, "t6_busy");
    repeat (3) tick();
    checkOutput("t6_in_frame", 32'(active), 32'(1));
    ext_busy = 1'b1;
    doReset();
    applyStimulus(4'b0001, 32'h0000_0082);
    sends = 0;
    repeat (40) begin
      tick();
      if (tx_send) sends++;
    end
    checkOutput("t6_no_send_busy", 32'(sends), 32'(0));
    ext_busy = 1'b0;
    waitSend(10, "t6_send_after", lat);
    checkOutput("t6_grant", 32'(grant), 32'(4'b0001));
    checkOutput("t6_data", 32'(tx_data), 32'(8'h82));
    waitIdle(100, "t6_idle");

    // Randomized traffic against the scoreboard.
    doReset();
    auto_drop = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      busy_len = $urandom_range(1, 6);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          if (grant[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
          else if (!grant[i] && $urandom_range(0, 49) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_data[i*DATA_W +: DATA_W] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    auto_drop = 1'b1;
    waitIdle(100, "t7_idle");
    checkOutput("t7_enough_frames", 32'(grant_log.size() >= 20), 32'(1));
    checkOutput("t7_err_clear", 32'(err_timeout), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_rr_arbiter.md
Name: uart_tx_rr_arbiter

Overview:
- Shares one single-frame UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sits between requester logic (sensor/status/debug producers) and the uart_single_frame_tx instance.
- Drives that instance's send/data inputs and watches its busy output.
- Sequences exactly one frame at a time, returns a one-cycle grant to the winning requester, and recovers with an error flag if the transmitter never starts.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width per requester
START_TIMEOUT, 16, cycles to wait for tx_busy to rise after a send pulse before aborting

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request; held high with data stable until grant
req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i at bits [i*DATA_W +: DATA_W]
grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted
tx_send  output  1  one-cycle start pulse to UART TX
tx_data  output  DATA_W  byte to UART TX; stable from the send pulse until the frame ends
tx_busy  input  1  busy from UART TX
active  output  1  high while a frame is owned (states LAUNCH..WAIT_DONE)
owner  output  clog2(NUM_REQ)  index of current/last winner
err_timeout  output  1  sticky; set when START_TIMEOUT expires; cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant=0, tx_send=0, tx_data=0, active=0, owner=NUM_REQ-1 (so requester 0 has first priority), err_timeout=0, timeout counter=0.
- All outputs are registered.
- IDLE:
  - If tx_busy=0 and any req is high, pick the first requester with req high, searching circularly from owner+1.
  - On that edge: owner<=winner, tx_data<=req_data[winner], tx_send<=1, grant[winner]<=1, active<=1, state<=LAUNCH.
  - If tx_busy=1 in IDLE (external/stale frame), nothing is issued.
- LAUNCH (1 cycle): tx_send<=0, grant<=0, counter cleared, state<=WAIT_BUSY.
  - Grant and send are high in the same cycle; latency from req to grant is 1 cycle when idle.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise counter increments; when counter reaches START_TIMEOUT-1 with busy still low: err_timeout<=1, active<=0, state<=IDLE.
  - The aborted byte is not retried; its grant was already given.
- WAIT_DONE: when tx_busy=0: active<=0, state<=IDLE. A new grant is possible on the next cycle (one-cycle gap between frames minimum).
- Requester handshake:
  - A requester that drops req before its grant simply loses its turn; no grant is issued for it.
  - After a grant, a requester holding req high is treated as a new request.
  - Round-robin gives it lowest priority next round.
- Simultaneous requests are resolved in one cycle by the rotating priority. No starvation: any continuously asserted req is granted within NUM_REQ frames.
- req changes during LAUNCH/WAIT_* are ignored until IDLE.
- tx_data is held until the next launch; it is not cleared at frame end.
- Reset mid-frame: outputs return to reset values immediately. The UART TX may still be busy; the arbiter waits in IDLE until tx_busy=0 before issuing.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE
  - DATA_W default
  - helper function for the clog2 owner width
- One sub-module is natural: rr_pick (combinational rotating-priority encoder: req vector + last owner -> valid + winner index), reusable by other arbiters.
- The FSM, timeout counter and output registers stay in uart_tx_rr_arbiter.

Test Plan:
- Single request: req=0001, req_data[0]=8'h41, TX model raises busy 1 cycle after send for 10 cycles -> grant=0001 and tx_send for one cycle, tx_data=8'h41, active high until busy falls, exactly one frame.
- Contention: req=1111 held continuously, distinct bytes 8'h30..8'h33 -> grants in order 0,1,2,3,0 with at least one idle cycle between frames, each tx_data matching its winner.
- Rotation skip: owner=1, req=1001 -> requester 3 wins, then requester 0 on the next frame.
- Withdraw: req[2] pulsed high then low while a frame for requester 0 is in WAIT_DONE -> no grant ever issued to requester 2.
- Timeout: TX model never asserts busy, START_TIMEOUT=16 -> err_timeout=1 exactly 16 cycles after LAUNCH exits; active=0; the next pending req is granted normally and err_timeout stays 1.
- Reset mid-frame: rst_n low during WAIT_DONE with tx_busy still 1 -> outputs reset immediately; after release with req=0001, no tx_send until tx_busy=0, then a normal grant to requester 0.
